// File: rtl/pll_seq_pkg.sv
// Shared state encoding and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;

    localparam logic [2:0] ST_PLL_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        PLL_RESET = ST_PLL_RESET,
        WAIT_LOCK = ST_WAIT_LOCK,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN,
        FAULT     = ST_FAULT
    } state_t;

    // Number of bits needed to hold values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        int unsigned w;
        w = 1;
        while ((max_count >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into the clk domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for stable lock, then
// releases domain resets one by one with retry and fault handling.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_RESETS          = 3,
    parameter int unsigned RESET_HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned STAGGER_CYCLES      = 8,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pll_lock,
    input  logic                               bypass_req,
    input  logic                               soft_reset,
    output logic                               pll_resetb,
    output logic                               pll_bypass,
    output logic [NUM_RESETS-1:0]              rst_out,
    output logic                               locked,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int unsigned CW = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_RESETS - 1) * STAGGER_CYCLES);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    state_t                state;
    state_t                state_n;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_n;
    logic [CW-1:0]         stable;
    logic [CW-1:0]         stable_n;
    logic [RW-1:0]         retry_n;
    logic [RW-1:0]         retry_inc;
    logic [NUM_RESETS-1:0] rst_next;
    logic                  lock_s;
    logic                  lock_ok;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Bypass stands in for lock so a bypassed PLL never times out.
    assign lock_ok   = lock_s | pll_bypass;
    assign retry_inc = retry_count + 1'b1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        stable_n = '0;
        retry_n  = retry_count;

        if (soft_reset) begin
            state_n = PLL_RESET;
            retry_n = '0;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (cnt == HOLD_LAST) begin
                        state_n = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        stable_n = stable + 1'b1;
                    end
                    if (lock_ok && (stable == STABLE_LAST)) begin
                        state_n = RELEASE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_n = retry_inc;
                        state_n = (retry_inc == RETRY_LIMIT) ? FAULT : PLL_RESET;
                    end
                end
                RELEASE: begin
                    if (!lock_ok) begin
                        state_n = PLL_RESET;
                    end else if (cnt == RELEASE_LAST) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (!lock_ok || (bypass_req != pll_bypass)) begin
                        state_n = PLL_RESET;
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = PLL_RESET;
                end
            endcase
        end

        if (soft_reset || (state_n != state)) begin
            cnt_n    = '0;
            stable_n = '0;
        end
        if (state_n == RUN) begin
            retry_n = '0;
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_comb begin
        rst_next = '1;
        case (state_n)
            RELEASE: begin
                for (int unsigned i = 0; i < NUM_RESETS; i++) begin
                    rst_next[i] = (cnt_n < CW'(i * STAGGER_CYCLES));
                end
            end
            RUN:     rst_next = '0;
            default: rst_next = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            stable      <= '0;
            retry_count <= '0;
            pll_resetb  <= 1'b0;
            pll_bypass  <= 1'b0;
            rst_out     <= '1;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            stable      <= stable_n;
            retry_count <= retry_n;
            pll_resetb  <= (state_n == WAIT_LOCK) || (state_n == RELEASE) || (state_n == RUN);
            pll_bypass  <= bypass_req;
            rst_out     <= rst_next;
            locked      <= (state_n == RUN);
            fault       <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random
// stimulus, all compared against a timestamp-based behavioural model.
module tb_pll_reset_sequencer;

    localparam int NR    = 3;
    localparam int HOLD  = 4;
    localparam int STAB  = 8;
    localparam int TMO   = 64;
    localparam int STAG  = 2;
    localparam int MAXR  = 2;
    localparam logic [8:0] RST_VEC = 9'b0_0_111_0_0_00;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pll_lock = 1'b0;
    logic          bypass_req = 1'b0;
    logic          soft_reset = 1'b0;
    logic          pll_resetb;
    logic          pll_bypass;
    logic [NR-1:0] rst_out;
    logic          locked;
    logic          fault;
    logic [1:0]    retry_count;
    logic [8:0]    obs;

    int n_pass  = 0;
    int n_total = 0;

    pll_reset_sequencer #(
        .NUM_RESETS          (NR),
        .RESET_HOLD_CYCLES   (HOLD),
        .LOCK_STABLE_CYCLES  (STAB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .STAGGER_CYCLES      (STAG),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .bypass_req  (bypass_req),
        .soft_reset  (soft_reset),
        .pll_resetb  (pll_resetb),
        .pll_bypass  (pll_bypass),
        .rst_out     (rst_out),
        .locked      (locked),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    assign obs = {pll_resetb, pll_bypass, rst_out, locked, fault, retry_count};

    // Behavioural model: phase name, entry timestamp, lock history, retry tally.
    string      m_phase = "HOLD";
    int         m_cyc = 0;
    int         m_enter = 0;
    int         m_run = 0;
    int         m_retries = 0;
    logic       m_byp = 1'b0;
    logic       m_d1 = 1'b0;
    logic       m_d2 = 1'b0;
    logic [8:0] m_exp = RST_VEC;

    // Advances the model across the next rising edge using the inputs now driven.
    task automatic model_step();
        logic       lk;
        logic       ok;
        int         age;
        string      nxt;
        logic [2:0] r;
        lk   = m_d2;
        m_d2 = m_d1;
        m_d1 = pll_lock;
        if (reset) begin
            m_phase   = "HOLD";
            m_enter   = m_cyc + 1;
            m_retries = 0;
            m_run     = 0;
            m_byp     = 1'b0;
            m_d1      = 1'b0;
            m_d2      = 1'b0;
        end else begin
            ok  = lk || m_byp;
            age = m_cyc - m_enter;
            nxt = m_phase;
            if (soft_reset) begin
                nxt       = "HOLD";
                m_retries = 0;
            end else if (m_phase == "HOLD") begin
                if (age + 1 == HOLD) nxt = "WAIT";
            end else if (m_phase == "WAIT") begin
                m_run = ok ? m_run + 1 : 0;
                if (m_run == STAB) begin
                    nxt = "REL";
                end else if (age + 1 == TMO) begin
                    m_retries = m_retries + 1;
                    nxt = (m_retries == MAXR) ? "FAULT" : "HOLD";
                end
            end else if (m_phase == "REL") begin
                if (!ok) nxt = "HOLD";
                else if (age == (NR - 1) * STAG) nxt = "RUN";
            end else if (m_phase == "RUN") begin
                if (!ok || (bypass_req != m_byp)) nxt = "HOLD";
            end
            if (soft_reset || (nxt != m_phase)) begin
                m_enter = m_cyc + 1;
                m_run   = 0;
            end
            if (nxt == "RUN") m_retries = 0;
            m_phase = nxt;
            m_byp   = bypass_req;
        end
        m_cyc = m_cyc + 1;
        age   = m_cyc - m_enter;
        r     = 3'b111;
        if (m_phase == "RUN") begin
            r = 3'b000;
        end else if (m_phase == "REL") begin
            for (int i = 0; i < NR; i++) r[i] = (age < i * STAG);
        end
        m_exp = {(m_phase == "WAIT") || (m_phase == "REL") || (m_phase == "RUN"),
                 m_byp, r, (m_phase == "RUN"), (m_phase == "FAULT"), 2'(m_retries)};
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge of cycle 0 after reset release.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pll_lock = 1'b0; bypass_req = 1'b0; soft_reset = 1'b0;
        do_reset();
        n_total++;
        if (obs !== RST_VEC) $display("FAIL reset_values got=%b exp=%b", obs, RST_VEC);
        else n_pass++;
        n_total++;
        if (obs !== m_exp) $display("FAIL reset_model got=%b exp=%b", obs, m_exp);
        else n_pass++;
    endtask

    task automatic test_lock_sequence();
        int f_rb = -1, f_110 = -1, f_100 = -1, f_000 = -1, f_lk = -1;
        pll_lock = 1'b0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL lock_seq_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            if (pll_resetb && f_rb < 0) f_rb = c;
            if (rst_out == 3'b110 && f_110 < 0) f_110 = c;
            if (rst_out == 3'b100 && f_100 < 0) f_100 = c;
            if (rst_out == 3'b000 && f_000 < 0) f_000 = c;
            if (locked && f_lk < 0) f_lk = c;
            pll_lock = (c >= 5);
            tick();
        end
        n_total++;
        if (f_rb != 4) $display("FAIL resetb_rise_cycle got=%0d exp=4", f_rb); else n_pass++;
        n_total++;
        if (f_110 != 15) $display("FAIL rst0_release_cycle got=%0d exp=15", f_110); else n_pass++;
        n_total++;
        if (f_100 != 17) $display("FAIL rst1_release_cycle got=%0d exp=17", f_100); else n_pass++;
        n_total++;
        if (f_000 != 19) $display("FAIL rst2_release_cycle got=%0d exp=19", f_000); else n_pass++;
        n_total++;
        if (f_lk != 20) $display("FAIL locked_cycle got=%0d exp=20", f_lk); else n_pass++;
    endtask

    task automatic test_timeout_fault();
        int f_r1 = -1, f_ft = -1;
        pll_lock = 1'b0;
        do_reset();
        for (int c = 0; c < 145; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL timeout_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            if (retry_count == 2'd1 && f_r1 < 0) f_r1 = c;
            if (fault && f_ft < 0) f_ft = c;
            tick();
        end
        n_total++;
        if (f_r1 != 68) $display("FAIL first_retry_cycle got=%0d exp=68", f_r1); else n_pass++;
        n_total++;
        if (f_ft != 136) $display("FAIL fault_cycle got=%0d exp=136", f_ft); else n_pass++;
        n_total++;
        if ({fault, pll_resetb, rst_out, locked} !== 6'b1_0_111_0)
            $display("FAIL fault_outputs got=%b exp=%b", {fault, pll_resetb, rst_out, locked}, 6'b1_0_111_0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int f_rel = -1;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL glitch_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            if (pll_resetb && rst_out != 3'b111 && f_rel < 0) f_rel = c;
            pll_lock = (c != 7);
            tick();
        end
        n_total++;
        if (f_rel != 18) $display("FAIL glitch_release_cycle got=%0d exp=18", f_rel); else n_pass++;
    endtask

    task automatic test_lock_drop();
        int f_relock = -1;
        pll_lock = 1'b1;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL drop_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            if (c == 27) begin
                n_total++;
                if (locked !== 1'b1) $display("FAIL drop_still_locked got=%b exp=1", locked); else n_pass++;
            end
            if (c == 28) begin
                n_total++;
                if ({rst_out, locked} !== 4'b111_0) $display("FAIL drop_reaction got=%b exp=1110", {rst_out, locked});
                else n_pass++;
            end
            if (c > 28 && locked && f_relock < 0) f_relock = c;
            pll_lock = !(c >= 25 && c <= 29);
            tick();
        end
        n_total++;
        if (f_relock != 45) $display("FAIL relock_cycle got=%0d exp=45", f_relock); else n_pass++;
    endtask

    task automatic test_soft_reset_bypass();
        int f_lk = -1, bad = 0;
        pll_lock = 1'b0; bypass_req = 1'b0;
        do_reset();
        for (int c = 0; c < 175; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL softrst_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            if (c == 140) begin
                n_total++;
                if (fault !== 1'b1) $display("FAIL softrst_in_fault got=%b exp=1", fault); else n_pass++;
            end
            if (c > 140 && (fault || retry_count != 2'd0)) bad++;
            if (c > 140 && locked && f_lk < 0) f_lk = c;
            soft_reset = (c == 140);
            if (c == 140) bypass_req = 1'b1;
            tick();
        end
        n_total++;
        if (bad != 0) $display("FAIL bypass_no_timeout got=%0d exp=0", bad); else n_pass++;
        n_total++;
        if (f_lk != 158) $display("FAIL bypass_run_cycle got=%0d exp=158", f_lk); else n_pass++;
    endtask

    // Continues from RUN-in-bypass left by the previous scenario.
    task automatic test_bypass_change();
        int f_lk = -1;
        for (int c = 0; c < 45; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL bypchg_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            if (c == 5) begin
                n_total++;
                if ({locked, pll_bypass} !== 2'b11) $display("FAIL bypchg_pre got=%b exp=11", {locked, pll_bypass});
                else n_pass++;
            end
            if (c == 6) begin
                n_total++;
                if ({pll_bypass, locked, pll_resetb} !== 3'b000)
                    $display("FAIL bypchg_resequence got=%b exp=000", {pll_bypass, locked, pll_resetb});
                else n_pass++;
            end
            if (c > 6 && locked && f_lk < 0) f_lk = c;
            pll_lock = 1'b1;
            if (c == 5) bypass_req = 1'b0;
            tick();
        end
        n_total++;
        if (f_lk != 23) $display("FAIL bypchg_relock_cycle got=%0d exp=23", f_lk); else n_pass++;
    endtask

    task automatic test_reset_mid_release();
        pll_lock = 1'b1; bypass_req = 1'b0;
        do_reset();
        for (int c = 0; c < 14; c++) tick();
        n_total++;
        if (rst_out !== 3'b100) $display("FAIL midrel_rst_out got=%b exp=100", rst_out); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (obs !== RST_VEC) $display("FAIL midrel_reset got=%b exp=%b", obs, RST_VEC); else n_pass++;
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL midrel_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        int rate;
        pll_lock = 1'b1; bypass_req = 1'b0; soft_reset = 1'b0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            n_total++;
            if (obs !== m_exp) $display("FAIL random_model cyc=%0d got=%b exp=%b", c, obs, m_exp);
            else n_pass++;
            rate       = ((c / 1000) % 2 == 1) ? 12 : 60;
            soft_reset = ($urandom_range(0, 399) == 0);
            reset      = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, rate - 1) == 0) pll_lock = ~pll_lock;
            if ($urandom_range(0, 249) == 0) bypass_req = ~bypass_req;
            tick();
        end
        reset = 1'b0; soft_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout_fault();
        test_glitch();
        test_lock_drop();
        test_soft_reset_bypass();
        test_bypass_change();
        test_reset_mid_release();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
